muldiv_ctrl: RTL
================

# muldiv_ctrl

Iterative multiply/divide sequencer for the multicycle MIPS core. It executes mult, multu, div and divu on two register operands over WIDTH+2 cycles, and owns the HI/LO registers for mfhi, mflo, mthi and mtlo. The main control FSM issues `start` from its execute state and holds in a wait state while `busy` is high. It advances when `done` pulses.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; 0 forces reset state
- start  in  1  issue the operation selected by `funct`; sampled only in IDLE
- funct  in  6  R-type funct field
- srca  in  WIDTH  rs operand (multiplicand/dividend; mthi/mtlo source)
- srcb  in  WIDTH  rt operand (multiplier/divisor)
- busy  out  1  operation in progress (MUL, DIV, FIX, DONE)
- done  out  1  one-cycle completion pulse
- divzero  out  1  valid with `done`; divisor was zero
- rdata  out  WIDTH  HI when funct=mfhi, LO otherwise; combinational

## Operation
- funct codes:
  - mfhi 0x10, mthi 0x11, mflo 0x12, mtlo 0x13
  - mult 0x18, multu 0x19, div 0x1A, divu 0x1B
- Any other funct with `start` is ignored: no state change, no `done`.
- FSM states are IDLE, MUL, DIV, FIX, DONE.
  - IDLE + start + mult/multu -> MUL.
  - IDLE + start + div/divu with srcb≠0 -> DIV.
  - IDLE + start + div/divu with srcb=0 -> DONE; `divzero`=1 in that cycle; HI/LO unchanged.
  - MUL/DIV run WIDTH iterations, then -> FIX -> DONE -> IDLE.
- mthi/mtlo: in IDLE with start, HI or LO <= srca at that edge. Stays in IDLE; no `busy`, no `done`.
- mfhi/mflo need no `start`. `rdata` always reflects the current HI/LO. While busy it returns the pre-operation value.
- Signed ops latch |srca|, |srcb| and result-sign flags at start; unsigned ops latch raw operands.
- Multiply: shift-add, one multiplier bit per cycle, 2·WIDTH-bit product register.
- Divide: restoring, one quotient bit per cycle, (WIDTH+1)-bit partial remainder.
- FIX sign correction:
  - Signed product is negated over the full 2·WIDTH bits if sign(a)^sign(b).
  - Signed quotient is negated if sign(a)^sign(b).
  - Signed remainder takes the sign of the dividend.
- Results are written at the edge entering DONE: HI=product[2W-1:W] / remainder, LO=product[W-1:0] / quotient.
- Overflow case div 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. No trap.
- `start` in any state other than IDLE is ignored; the in-flight operation is unaffected.

## Timing
- Reset values: state=IDLE, HI=LO=0, busy=0, done=0, divzero=0, internal operand/shift registers=0.
- `reset` low mid-operation aborts immediately and asynchronously. Partial results are discarded and HI/LO clear to 0.
- Latency for a start sampled at edge N (mult/div, divisor≠0):
  - MUL/DIV during cycles N+1..N+WIDTH
  - FIX during cycle N+WIDTH+1
  - DONE during cycle N+WIDTH+2 (WIDTH=32: done 34 cycles after start)
- Divide-by-zero latency: DONE during cycle N+1.
- `busy` goes high in the cycle after the start edge and falls the cycle after DONE. `done` is high exactly one cycle.
- Back-to-back: a new `start` is accepted in the first IDLE cycle after DONE.
- Iteration counter: log2(WIDTH)+1 bits; the terminal count is WIDTH-1.

## Structure
- Package `muldiv_pkg`:
  - funct localparams (F_MFHI … F_DIVU)
  - `muldiv_state_t` enum {IDLE, MUL, DIV, FIX, DONE}
- Natural sub-module `muldiv_iter` holds the datapath:
  - product/remainder shift register, adder/subtractor, operand registers
  - inputs: load, step, mode (mul/div), plus operands
  - output: the raw 2·WIDTH-bit result
- `muldiv_ctrl` keeps the FSM, the counter, sign flags, FIX negation, and HI/LO.

## Test plan
- multu 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; `done` 34 cycles after start; `busy` high for cycles 1–34.
- mult 0xFFFFFFFD (-3) × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- div 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/2 -> LO=3, HI=1; div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- mthi 0x1234, mtlo 0x5678, then divu 5/0 -> `done`+`divzero` one cycle after start; mfhi reads 0x1234; mflo reads 0x5678.
- Start mult 3×4; pulse `start` with divu 9/3 at cycle 5 -> ignored; result HI=0, LO=12; `done` once.
- Start div 100/7; drive `reset` low at cycle 10 -> `busy`=0 immediately, HI=LO=0, no `done`; a following divu 100/7 -> LO=14, HI=2.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: funct codes and FSM states.
package muldiv_pkg;

    // R-type funct codes handled by the HI/LO unit
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } muldiv_state_t;

    // Signed variants need magnitude operands and sign correction afterwards
    function automatic logic is_signed_op(input logic [5:0] f);
        return (f == F_MULT) || (f == F_DIV);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative datapath: shift-add multiplier and restoring divider sharing one
// operand register and one upper/lower shift register pair.
//  mul: upper = partial product high half, lower = multiplier shifting out
//  div: upper = partial remainder, lower = dividend shifting out / quotient in
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic                 div_i,
    input  logic [WIDTH-1:0]     op_a_i,
    input  logic [WIDTH-1:0]     op_b_i,
    output logic [2*WIDTH-1:0]   result_o
);

    logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand or divisor
    logic [WIDTH:0]   upper_q, upper_d; // product high half / partial remainder
    logic [WIDTH-1:0] lower_q, lower_d; // multiplier / dividend -> quotient
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH+1:0] div_diff;

    // Adder for mul, trial subtract of the shifted remainder for div
    always_comb begin
        mul_sum  = upper_q + (lower_q[0] ? {1'b0, opnd_q} : '0);
        div_diff = {upper_q, lower_q[WIDTH-1]} - {2'b00, opnd_q};
    end

    // Next-state for operand and shift registers
    always_comb begin
        opnd_d  = opnd_q;
        upper_d = upper_q;
        lower_d = lower_q;
        if (load_i) begin
            opnd_d  = div_i ? op_b_i : op_a_i;
            upper_d = '0;
            lower_d = div_i ? op_a_i : op_b_i;
        end else if (step_i) begin
            if (div_i) begin
                // Restore when the trial subtraction went negative
                if (div_diff[WIDTH+1]) begin
                    upper_d = {upper_q[WIDTH-1:0], lower_q[WIDTH-1]};
                    lower_d = {lower_q[WIDTH-2:0], 1'b0};
                end else begin
                    upper_d = div_diff[WIDTH:0];
                    lower_d = {lower_q[WIDTH-2:0], 1'b1};
                end
            end else begin
                // Carry of the add shifts into the top, LSB into lower half
                upper_d = {1'b0, mul_sum[WIDTH:1]};
                lower_d = {mul_sum[0], lower_q[WIDTH-1:1]};
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            opnd_q  <= '0;
            upper_q <= '0;
            lower_q <= '0;
        end else begin
            opnd_q  <= opnd_d;
            upper_q <= upper_d;
            lower_q <= lower_d;
        end
    end

    assign result_o = {upper_q[WIDTH-1:0], lower_q};

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer: FSM, iteration counter, sign handling, and the
// architectural HI/LO registers.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] rdata
);

    localparam int CW = $clog2(WIDTH) + 1;

    muldiv_state_t    state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;   // negate product / quotient
    logic             neg_rem_q, neg_rem_d;   // negate remainder
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             op_mul, op_div, op_sgn, sign_a, sign_b;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic             idle_start, load, step, iter_div, last;
    logic [2*WIDTH-1:0] raw, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    // Decode the request and form magnitude operands for signed ops
    always_comb begin
        op_mul     = (funct == F_MULT) || (funct == F_MULTU);
        op_div     = (funct == F_DIV)  || (funct == F_DIVU);
        op_sgn     = is_signed_op(funct);
        sign_a     = op_sgn & srca[WIDTH-1];
        sign_b     = op_sgn & srcb[WIDTH-1];
        abs_a      = sign_a ? -srca : srca;
        abs_b      = sign_b ? -srcb : srcb;
        idle_start = (state_q == IDLE) && start;
        load       = idle_start && (op_mul || (op_div && (srcb != '0)));
        step       = (state_q == MUL) || (state_q == DIV);
        iter_div   = load ? op_div : is_div_q;
        last       = (cnt_q == CW'(WIDTH - 1));
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk_i    (clk),
        .rst_ni   (reset),
        .load_i   (load),
        .step_i   (step),
        .div_i    (iter_div),
        .op_a_i   (abs_a),
        .op_b_i   (abs_b),
        .result_o (raw)
    );

    // Sign correction applied on the way into HI/LO
    always_comb begin
        prod_fix = neg_res_q ? -raw : raw;
        quo_fix  = neg_res_q ? -raw[WIDTH-1:0] : raw[WIDTH-1:0];
        rem_fix  = neg_rem_q ? -raw[2*WIDTH-1:WIDTH] : raw[2*WIDTH-1:WIDTH];
    end

    // Next-state, counter, latched flags and HI/LO updates
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        unique case (state_q)
            IDLE: begin
                if (idle_start) begin
                    if (funct == F_MTHI) begin
                        hi_d = srca;
                    end else if (funct == F_MTLO) begin
                        lo_d = srca;
                    end else if (op_div && (srcb == '0)) begin
                        // Divide by zero: report and leave HI/LO alone
                        state_d = DONE;
                        dz_d    = 1'b1;
                    end else if (load) begin
                        state_d   = op_div ? DIV : MUL;
                        cnt_d     = '0;
                        is_div_d  = op_div;
                        neg_res_d = sign_a ^ sign_b;
                        neg_rem_d = sign_a;
                        dz_d      = 1'b0;
                    end
                end
            end
            MUL, DIV: begin
                cnt_d = cnt_q + CW'(1);
                if (last) state_d = FIX;
            end
            FIX: begin
                state_d = DONE;
                dz_d    = 1'b0;
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Counter, flags and architectural HI/LO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign divzero = done & dz_q;
    assign rdata   = (funct == F_MFHI) ? hi_q : lo_q;

endmodule
